// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared definitions for the SPI-to-register-bus bridge.
//   - state_e           : bridge FSM state encoding
//   - RW_BIT / IDX_LSB  : command-byte field positions
//   - FRAME_BYTES       : command byte plus four data bytes
//   - DEFAULT_BASE_ADDR : register-bus address of word index 0
package spi_reg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StWrite,
        StRdreq,
        StRdcap,
        StRdshift,
        StDone
    } state_e;

    localparam int unsigned RW_BIT      = 7;
    localparam int unsigned IDX_LSB     = 0;
    localparam int unsigned FRAME_BYTES = 5;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h3000;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings the asynchronous SPI pins into the ACLK domain and
// produces single-cycle edge strobes.
// Ports:
//   ACLK, ARESETN       system clock, async active-low reset
//   SCK, SSEL, MOSI     raw SPI pins
//   sck_rise, sck_fall  one-cycle strobes on synchronized SCK edges
//   ssel_rise, ssel_fall one-cycle strobes on synchronized SSEL edges
//   ssel_s              synchronized SSEL level
//   mosi_s              synchronized MOSI, aligned with the SCK samples
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic SCK,
    input  logic SSEL,
    input  logic MOSI,
    output logic sck_rise,
    output logic sck_fall,
    output logic ssel_rise,
    output logic ssel_fall,
    output logic ssel_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ssel_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_edge_q;
    logic                   ssel_edge_q;

    // SSEL resets to 0 (looks selected): a frame already in progress when reset
    // is released can never produce a falling edge, so the bridge only starts
    // after SSEL has been seen high.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sck_sync_q  <= '0;
            ssel_sync_q <= '0;
            mosi_sync_q <= '0;
            sck_edge_q  <= 1'b0;
            ssel_edge_q <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], SSEL};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_edge_q  <= sck_sync_q[SYNC_STAGES-1];
            ssel_edge_q <= ssel_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise  = sck_sync_q[SYNC_STAGES-1] & ~sck_edge_q;
    assign sck_fall  = ~sck_sync_q[SYNC_STAGES-1] & sck_edge_q;
    assign ssel_rise = ssel_sync_q[SYNC_STAGES-1] & ~ssel_edge_q;
    assign ssel_fall = ~ssel_sync_q[SYNC_STAGES-1] & ssel_edge_q;
    assign ssel_s    = ssel_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns 5-byte frames (command byte plus
// 32-bit word, MSB first) into single-word register-bus reads and writes.
// Ports:
//   ACLK, ARESETN          system clock, async active-low reset
//   SCK, SSEL, MOSI, MISO  SPI slave pins (SSEL active-low)
//   WRADDR, BYTEEN, WREN, WDATA  register-bus write port (WREN one cycle)
//   RDADDR, RDEN, RDATA    register-bus read port (RDATA valid cycle after RDEN)
//   FRAME_ERR              one-cycle pulse when a frame is cut short
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDX_WIDTH   = 6
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        SCK,
    input  logic        SSEL,
    input  logic        MOSI,
    output logic        MISO,
    output logic [15:0] WRADDR,
    output logic [3:0]  BYTEEN,
    output logic        WREN,
    output logic [31:0] WDATA,
    output logic [15:0] RDADDR,
    output logic        RDEN,
    input  logic [31:0] RDATA,
    output logic        FRAME_ERR
);

    logic sck_rise, sck_fall, ssel_rise, ssel_fall, ssel_s, mosi_s;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .SCK      (SCK),
        .SSEL     (SSEL),
        .MOSI     (MOSI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ssel_rise(ssel_rise),
        .ssel_fall(ssel_fall),
        .ssel_s   (ssel_s),
        .mosi_s   (mosi_s)
    );

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] tx_q, tx_d;
    logic        shift_pend_q, shift_pend_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wraddr_q, wraddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] rdaddr_q, rdaddr_d;
    logic        frame_err_q, frame_err_d;

    logic [31:0] rx_word;
    logic [15:0] cmd_addr;
    logic        last_bit;
    logic        last_byte;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            shift_pend_q <= 1'b0;
            addr_q       <= '0;
            wraddr_q     <= '0;
            wdata_q      <= '0;
            rdaddr_q     <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            shift_pend_q <= shift_pend_d;
            addr_q       <= addr_d;
            wraddr_q     <= wraddr_d;
            wdata_q      <= wdata_d;
            rdaddr_q     <= rdaddr_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        shift_pend_d = shift_pend_q;
        addr_d       = addr_q;
        wraddr_d     = wraddr_q;
        wdata_d      = wdata_q;
        rdaddr_d     = rdaddr_q;
        frame_err_d  = 1'b0;

        // Word as it will look once the current MOSI sample is shifted in.
        rx_word   = {rx_q[30:0], mosi_s};
        cmd_addr  = BASE_ADDR + 16'({rx_word[IDX_LSB +: IDX_WIDTH], 2'b00});
        last_bit  = (bit_cnt_q == 3'd7);
        last_byte = (byte_cnt_q == 3'(FRAME_BYTES - 1));

        unique case (state_q)
            StIdle: begin
                if (ssel_fall) begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    rx_d       = '0;
                    state_d    = StCmd;
                end
            end

            StCmd: begin
                if (ssel_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (sck_rise) begin
                    rx_d      = rx_word;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (rx_word[RW_BIT]) begin
                            rdaddr_d = cmd_addr;
                            state_d  = StRdreq;
                        end else begin
                            addr_d  = cmd_addr;
                            state_d = StWdata;
                        end
                    end
                end
            end

            StWdata: begin
                // The final rise completes the frame even if SSEL rose with it.
                if (sck_rise && last_bit && last_byte) begin
                    wdata_d  = rx_word;
                    wraddr_d = addr_q;
                    state_d  = StWrite;
                end else if (ssel_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (sck_rise) begin
                    rx_d      = rx_word;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end

            StWrite: begin
                state_d = StDone;
            end

            StRdreq: begin
                if (ssel_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    state_d = StRdcap;
                end
            end

            StRdcap: begin
                tx_d         = RDATA;
                shift_pend_d = 1'b0;
                if (ssel_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    state_d = StRdshift;
                end
            end

            StRdshift: begin
                if (sck_rise && last_bit && last_byte) begin
                    state_d = StDone;
                end else if (ssel_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (sck_rise) begin
                    bit_cnt_d    = bit_cnt_q + 3'd1;
                    shift_pend_d = 1'b1;
                    if (last_bit) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end else if (sck_fall && shift_pend_q) begin
                    // Only falls after a data-phase rise advance MISO; the fall
                    // closing the command byte leaves RDATA[31] in place.
                    tx_d         = {tx_q[30:0], 1'b0};
                    shift_pend_d = 1'b0;
                end
            end

            StDone: begin
                if (ssel_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign WREN      = (state_q == StWrite);
    assign BYTEEN    = {4{WREN}};
    assign WRADDR    = wraddr_q;
    assign WDATA     = wdata_q;
    assign RDEN      = (state_q == StRdreq);
    assign RDADDR    = rdaddr_q;
    assign MISO      = (state_q == StRdshift) & tx_q[31];
    assign FRAME_ERR = frame_err_q;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
SPI slave that converts serial command frames from the external controller into single-word register-bus accesses on the sound block (BASE 0x3000: ADDR, SIZE, VOL, CTRL).
- Sits directly upstream of the sound circuit's register-bus port, on the ACLK domain.
- Lets an external MCU set volume and issue PLAY/PAUSE/STOP, and read STATUS.
- SPI mode 0, MSB first. SSEL is active-low and frames each transaction.

Parameters:
- BASE_ADDR, 16'h3000, register-bus address of word index 0.
- SYNC_STAGES, 2, synchronizer depth for SCK/SSEL/MOSI (min 2).
- IDX_WIDTH, 6, width of the word-index field in the command byte.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- SCK  in  1  SPI clock, asynchronous to ACLK.
- SSEL  in  1  SPI slave select, active-low, asynchronous.
- MOSI  in  1  SPI data in, asynchronous.
- MISO  out  1  SPI data out.
- WRADDR  out  16  register-bus write address.
- BYTEEN  out  4  write byte enables; always 4'hf when WREN is asserted.
- WREN  out  1  one-cycle write strobe.
- WDATA  out  32  write data.
- RDADDR  out  16  register-bus read address.
- RDEN  out  1  one-cycle read strobe.
- RDATA  in  32  read data, valid the cycle after RDEN.
- FRAME_ERR  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
Reset values:
- All outputs are 0.
- FSM is in IDLE; shift registers and bit/byte counters are 0.
- ARESETN low mid-frame discards the frame. After release, the FSM waits for SSEL high before accepting a new frame.

Input sampling:
- SCK, SSEL and MOSI pass through SYNC_STAGES flops, then one more edge-detect flop.
- rise/fall are derived from the last two synchronized SCK samples.
- Requirement: SCK high and low phases are each ≥ 4 ACLK cycles.

Frame format:
- Byte 0 = command: bit7 = R/nW, bit6 reserved (ignored), bits[5:0] = index.
- Byte 0 is followed by 4 data bytes, MSB first.
- Address = BASE_ADDR + {index, 2'b00}.
- MOSI is sampled on synchronized SCK rise.

FSM states: IDLE, CMD, WDATA, WRITE, RDREQ, RDCAP, RDSHIFT, DONE.
- IDLE: waits for SSEL falling (synchronized); clears the bit counter → CMD.
- CMD: shifts 8 bits. On the 8th rise, latches the address; R/nW=0 → WDATA, 1 → RDREQ.
- WDATA: shifts 32 bits into a 32-bit register. On the 32nd rise → WRITE.
- WRITE: asserts WREN=1 and BYTEEN=4'hf for exactly one cycle, with WRADDR/WDATA stable in the same cycle → DONE.
- RDREQ: asserts RDEN=1 with RDADDR for one cycle → RDCAP.
- RDCAP: loads the MISO shift register from RDATA; MISO = RDATA[31] from the next cycle → RDSHIFT.
  - Total latency from the 8th command rise to valid MISO is 3 ACLK cycles, which is below the 4-cycle minimum half-period. The first data bit is therefore stable before the next SCK rise.
- RDSHIFT: on each fall that follows a data-phase rise, shift left and fill with 0. The fall following byte 0's 8th rise does not shift. After the 32nd rise → DONE.
- DONE: ignores SCK; MISO=0. Waits for SSEL high → IDLE.

Abort and error rules:
- SSEL rising in CMD, WDATA, RDREQ, RDCAP or RDSHIFT before completion → pulse FRAME_ERR for one cycle, issue no WREN, return to IDLE.
- SSEL rising in the same cycle WRITE is entered: the write still completes. The frame was complete, so no FRAME_ERR.
- Extra SCK edges in DONE are ignored; no second access occurs.
- SSEL falling while not in IDLE is impossible; SSEL must first be high.

Other rules:
- Outside RDSHIFT/RDCAP, MISO is 0.
- Index wrap: the index is used modulo 2^IDX_WIDTH; no range check.
- WRADDR/WDATA/RDADDR hold their last values between strobes.

Decomposition:
- Package spi_reg_pkg holds:
  - FSM state encoding.
  - Command-byte field positions (RW_BIT=7, IDX_LSB=0).
  - FRAME_BYTES=5.
  - Default BASE_ADDR.
- One sub-module is natural: spi_sync_edge. It synchronizes SCK/SSEL/MOSI and outputs sck_rise, sck_fall, ssel_fall, ssel_rise and mosi_s.

Test Plan:
- Write VOL: frame 0x02,00,00,00,FF with SCK half-period 15 ACLK → one WREN pulse, WRADDR=0x3008, BYTEEN=4'hf, WDATA=0x000000FF; FRAME_ERR never asserts.
- Write CTRL: frame 0x03,00,00,00,05 → WRADDR=0x300c, WDATA=0x00000005 (PLAY|LOOP); the sound block starts playing.
- Read: command 0x84, RDATA model returns 0xA5C3_0F81 the cycle after RDEN → RDADDR=0x3010, one RDEN pulse; MISO bits sampled on SCK rises of bytes 1-4 equal 0xA5C30F81.
- Abort: SSEL rises after 2 data bytes → no WREN, one FRAME_ERR pulse. The next full frame writes correctly.
- Trailing clocks: 48 SCK cycles in one frame → exactly one WREN; no FRAME_ERR on SSEL rise.
- Reset mid-frame: ARESETN low during byte 3 → all outputs 0. Bridge waits for SSEL high, then a fresh frame succeeds.
